aes_key_schedule: RTL

- On-the-fly AES-128 round-key generator.
- Sits directly downstream of the AES slave interface, in parallel with the round datapath.
- Holds the cipher key and presents one round key per cycle (rounds 0..10) for the round currently being executed.
- Replaces the static key path. Computes the next key from the current one each cycle; there is no key-expansion RAM.

---
 rtl/aes_key_schedule.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 round-key generator: presents one round key per cycle, no expansion RAM.
// Define AES_KEY_REVERSE_EN to honour dir and generate keys in reverse (decryption) order.
module aes_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         start,
  input  logic         advance,
  input  logic         dir,
  output logic [127:0] rkey,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  subIn, subOut, fwdT;
  logic [127:0] fwdKey;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box = affine(a^254); a^254 is the product of a^2, a^4, ... a^128 (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] base;
    inv  = 8'h01;
    base = a;
    for (int i = 0; i < 7; i++) begin
      base = gfMul(base, base);
      inv  = gfMul(inv, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign {w0, w1, w2, w3} = rkey_q;

`ifdef AES_KEY_REVERSE_EN
  logic         reverse_q, reverse_d;
  logic [127:0] lastKey_q, lastKey_d;
  logic         lastKeyValid_q, lastKeyValid_d;
  logic [31:0]  p0;
  logic [127:0] revKey;

  // One shared S-box bank: reverse steps substitute the recovered w3 instead of the current one.
  assign subIn  = reverse_q ? (w3 ^ w2) : w3;
  assign p0     = w0 ^ subOut ^ {rcon(round_q), 24'h0};
  assign revKey = {p0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
`else
  logic unusedDir;
  assign unusedDir = dir;
  assign subIn     = w3;
`endif

  assign subOut = subWord({subIn[23:0], subIn[31:24]});
  assign fwdT   = subOut ^ {rcon(round_q + 4'd1), 24'h0};
  assign fwdKey = {w0 ^ fwdT, w1 ^ w0 ^ fwdT, w2 ^ w1 ^ w0 ^ fwdT, w3 ^ w2 ^ w1 ^ w0 ^ fwdT};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef AES_KEY_REVERSE_EN
    reverse_d      = reverse_q;
    lastKey_d      = lastKey_q;
    lastKeyValid_d = lastKeyValid_q;
`endif
    if (state_q == IDLE && key_load) begin
      key_d = key_in;
`ifdef AES_KEY_REVERSE_EN
      lastKeyValid_d = 1'b0;
`endif
    end
    if (start) begin
`ifdef AES_KEY_REVERSE_EN
      if (dir && !lastKeyValid_d) begin
        err_d = 1'b1;
      end else if (dir) begin
        state_d   = RUN;
        rkey_d    = lastKey_q;
        round_d   = LAST_ROUND;
        err_d     = 1'b0;
        reverse_d = 1'b1;
      end else
`endif
      begin
        state_d = RUN;
        rkey_d  = key_d;
        round_d = 4'd0;
        err_d   = 1'b0;
`ifdef AES_KEY_REVERSE_EN
        reverse_d = 1'b0;
`endif
      end
    end else if (state_q == RUN && advance) begin
`ifdef AES_KEY_REVERSE_EN
      if (reverse_q) begin
        rkey_d  = revKey;
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end else
`endif
      begin
        rkey_d  = fwdKey;
        round_d = round_q + 4'd1;
        if (round_q + 4'd1 == LAST_ROUND) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef AES_KEY_REVERSE_EN
          lastKey_d      = fwdKey;
          lastKeyValid_d = 1'b1;
`endif
        end
      end
    end
    // A key change mid-sequence would corrupt the running schedule, so it is flagged, not applied.
    if (state_q == RUN && key_load) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      key_q   <= '0;
      rkey_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef AES_KEY_REVERSE_EN
      reverse_q      <= 1'b0;
      lastKey_q      <= '0;
      lastKeyValid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef AES_KEY_REVERSE_EN
      reverse_q      <= reverse_d;
      lastKey_q      <= lastKey_d;
      lastKeyValid_q <= lastKeyValid_d;
`endif
    end
  end

  assign rkey  = rkey_q;
  assign round = round_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign err   = err_q;

endmodule
